alarm_controller: RTL and testbench

//  Consumes the sec/min/hour counts of the clock timers; holds a user-set alarm time (HH:MM).

---
 rtl/alarm_controller_pkg.sv | 15 +
 rtl/alarm_controller_edge_pulse.sv | 23 ++
 rtl/alarm_controller.sv | 161 ++++++++++++++++
 tb/tb_alarm_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: FSM state encoding and
// wrap limits of the stored alarm time.
// Imported by alarm_controller and its testbench.
package alarm_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

endpackage

// File: rtl/alarm_controller_edge_pulse.sv
// edge_pulse: single-bit rising-edge detector.
// Ports:
//   clk_src - clock
//   reset   - asynchronous active-high reset (clears the previous-value register)
//   level   - level input to watch
//   pulse   - one-cycle high when level is 1 and was 0 on the previous clock
module edge_pulse (
  input  logic clk_src,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: holds a user-set HH:MM alarm time and rings when the
// running time from the timers reaches HH:MM:00 while armed.
// Optional feature macro: ALARM_SNOOZE_EN (adds SNOOZE state and counter;
// without it the snooze input is ignored).
// Ports:
//   clk_src            - single clock of the block
//   reset              - asynchronous active-high reset
//   tick               - one-cycle pulse per second
//   sec, min, hour     - current time, WIDTH bits each
//   set_mode           - 1: buttons edit the alarm time, forces IDLE
//   inc_min, inc_hour  - rising edge increments alarm minute / hour
//   arm                - 1: alarm armed
//   stop               - rising edge silences ringing
//   snooze             - rising edge starts snooze (feature macro only)
//   alarm_min/hour     - stored alarm time
//   ringing            - 1 while ringing
//   beep               - ringing gated by a 1 Hz pattern
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic             clk_src,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] sec,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] hour,
  input  logic             set_mode,
  input  logic             inc_min,
  input  logic             inc_hour,
  input  logic             arm,
  input  logic             stop,
  input  logic             snooze,
  output logic [5:0]       alarm_min,
  output logic [4:0]       alarm_hour,
  output logic             ringing,
  output logic             beep
);

  localparam int unsigned RING_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  logic min_edge, hour_edge, stop_edge, snooze_edge;

  edge_pulse u_inc_min  (.clk_src(clk_src), .reset(reset), .level(inc_min),  .pulse(min_edge));
  edge_pulse u_inc_hour (.clk_src(clk_src), .reset(reset), .level(inc_hour), .pulse(hour_edge));
  edge_pulse u_stop     (.clk_src(clk_src), .reset(reset), .level(stop),     .pulse(stop_edge));
  edge_pulse u_snooze   (.clk_src(clk_src), .reset(reset), .level(snooze),   .pulse(snooze_edge));

  // Alarm time storage; minute wrap never carries into the hour.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      alarm_min  <= '0;
      alarm_hour <= '0;
    end else if (set_mode) begin
      if (min_edge)
        alarm_min <= (alarm_min == 6'(MIN_MAX)) ? '0 : alarm_min + 6'd1;
      if (hour_edge)
        alarm_hour <= (alarm_hour == 5'(HOUR_MAX)) ? '0 : alarm_hour + 5'd1;
    end
  end

  logic match;
  assign match = arm && !set_mode &&
                 (hour == WIDTH'(alarm_hour)) &&
                 (min  == WIDTH'(alarm_min)) &&
                 (sec  == '0);

  state_t            state, state_n;
  logic [RING_W-1:0] ring_cnt, ring_cnt_n;
  logic              beep_phase, beep_phase_n;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;
  logic [11:0] snz_cnt, snz_cnt_n;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) snz_cnt <= '0;
    else       snz_cnt <= snz_cnt_n;
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze_edge ^ (SNOOZE_MIN != 0);
`endif

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      beep_phase <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      beep_phase <= beep_phase_n;
    end
  end

  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    beep_phase_n = beep_phase;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_n    = snz_cnt;
`endif
    if (set_mode) begin
      state_n      = ST_IDLE;
      beep_phase_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && match) begin
            state_n      = ST_RING;
            ring_cnt_n   = '0;
            beep_phase_n = 1'b0;
          end
        end
        ST_RING: begin
          // stop is checked before snooze so a simultaneous press ends in IDLE
          if (stop_edge || !arm) begin
            state_n = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_edge) begin
            state_n   = ST_SNOOZE;
            snz_cnt_n = '0;
`endif
          end else if (tick) begin
            if (ring_cnt == RING_W'(RING_SECS - 1)) begin
              state_n = ST_IDLE;
            end else begin
              ring_cnt_n   = ring_cnt + 1'b1;
              beep_phase_n = ~beep_phase;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_edge || !arm) begin
            state_n = ST_IDLE;
          end else if (tick) begin
            if (snz_cnt == 12'(SNOOZE_TICKS - 1)) begin
              state_n      = ST_RING;
              ring_cnt_n   = '0;
              beep_phase_n = 1'b0;
            end else begin
              snz_cnt_n = snz_cnt + 12'd1;
            end
          end
        end
`endif
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Decoded from flops only, so both drop together with the async reset.
  assign ringing = (state == ST_RING);
  assign beep    = ringing & beep_phase;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking testbench for alarm_controller.
module tb_alarm_controller;
  import alarm_controller_pkg::*;

  logic        clk_src = 1'b0;
  logic        reset;
  logic        tick;
  logic [31:0] sec, min, hour;
  logic        set_mode, inc_min, inc_hour, arm, stop, snooze;
  logic [5:0]  alarm_min;
  logic [4:0]  alarm_hour;
  logic        ringing, beep;

  int errors = 0;
  int checks = 0;

  alarm_controller #(.WIDTH(32), .RING_SECS(60), .SNOOZE_MIN(5)) dut (
    .clk_src(clk_src), .reset(reset), .tick(tick),
    .sec(sec), .min(min), .hour(hour),
    .set_mode(set_mode), .inc_min(inc_min), .inc_hour(inc_hour),
    .arm(arm), .stop(stop), .snooze(snooze),
    .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .ringing(ringing), .beep(beep)
  );

  always #5 clk_src = ~clk_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_src);
    #1;
  endtask

  task automatic pulse_tick(input int s, input int m, input int h);
    sec = s; min = m; hour = h;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic press_min();
    inc_min = 1'b1; cycle(); inc_min = 1'b0; cycle();
  endtask

  task automatic press_hour();
    inc_hour = 1'b1; cycle(); inc_hour = 1'b0; cycle();
  endtask

  task automatic press_stop();
    stop = 1'b1; cycle(); stop = 1'b0; cycle();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sec = '0; min = '0; hour = '0;
    set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    arm = 1'b0; stop = 1'b0; snooze = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check("reset_min", alarm_min, 0);
    check("reset_hour", alarm_hour, 0);
    check("reset_ringing", ringing, 0);
    check("reset_beep", beep, 0);

    // 1: set alarm, with wrap checks
    set_mode = 1'b1;
    repeat (7) press_hour();
    repeat (30) press_min();
    check("set_hour", alarm_hour, 7);
    check("set_min", alarm_min, 30);
    repeat (MIN_MAX + 1) press_min();
    check("min_wrap", alarm_min, 30);
    check("min_no_carry", alarm_hour, 7);
    repeat (HOUR_MAX + 1 - 7) press_hour();
    check("hour_wrap", alarm_hour, 0);
    repeat (7) press_hour();
    check("hour_back", alarm_hour, 7);
    inc_min = 1'b1; cycle(); cycle(); cycle(); inc_min = 1'b0; cycle();
    check("held_button_once", alarm_min, 31);
    repeat (MIN_MAX) press_min();
    check("min_restore", alarm_min, 30);
    set_mode = 1'b0;
    press_min();
    check("edit_needs_set_mode", alarm_min, 30);

    // 2: trigger, beep pattern, auto-stop
    arm = 1'b1;
    pulse_tick(59, 29, 7);
    check("no_ring_before", ringing, 0);
    pulse_tick(0, 30, 7);
    check("trig_ringing", ringing, 1);
    check("trig_beep0", beep, 0);
    for (int s = 1; s <= 3; s++) begin
      pulse_tick(s, 30, 7);
      check("beep_pattern", beep, s % 2);
    end
    for (int s = 4; s <= 59; s++) pulse_tick(s, 30, 7);
    check("ring_after_59_ticks", ringing, 1);
    pulse_tick(0, 31, 7);
    check("auto_stop", ringing, 0);
    check("auto_stop_beep", beep, 0);

    // 3: stop edge, no retrigger in the same minute
    pulse_tick(0, 30, 7);
    check("ring_again", ringing, 1);
    pulse_tick(1, 30, 7);
    pulse_tick(2, 30, 7);
    stop = 1'b1; cycle();
    check("stop_ringing", ringing, 0);
    stop = 1'b0; cycle();
    for (int s = 3; s <= 59; s++) begin
      pulse_tick(s, 30, 7);
      check("no_retrigger", ringing, 0);
    end

    // 4: disarm and set_mode guards
    arm = 1'b0;
    pulse_tick(0, 30, 7);
    check("disarmed_no_ring", ringing, 0);
    arm = 1'b1;
    pulse_tick(0, 30, 7);
    check("rearm_ring", ringing, 1);
    arm = 1'b0; cycle();
    check("arm_drop_idle", ringing, 0);
    arm = 1'b1; cycle();
    check("arm_back_stays_idle", ringing, 0);
    pulse_tick(0, 30, 7);
    check("ring_for_setmode", ringing, 1);
    set_mode = 1'b1; cycle();
    check("setmode_idle", ringing, 0);
    set_mode = 1'b0; cycle();
    set_mode = 1'b1;
    pulse_tick(0, 30, 7);
    check("setmode_at_match", ringing, 0);
    set_mode = 1'b0;
    check("alarm_kept_min", alarm_min, 30);
    check("alarm_kept_hour", alarm_hour, 7);

    // 5: snooze
    pulse_tick(0, 30, 7);
    check("ring_for_snooze", ringing, 1);
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1; cycle();
    check("snooze_enter", ringing, 0);
    snooze = 1'b0; cycle();
    repeat (299) pulse_tick(5, 30, 7);
    check("snooze_299", ringing, 0);
    pulse_tick(5, 30, 7);
    check("snooze_resume", ringing, 1);
    check("snooze_resume_beep", beep, 0);
    stop = 1'b1; snooze = 1'b1; cycle();
    check("stop_beats_snooze", ringing, 0);
    stop = 1'b0; snooze = 1'b0; cycle();
    repeat (300) pulse_tick(5, 30, 7);
    check("stop_snooze_idle", ringing, 0);
`else
    snooze = 1'b1; cycle();
    check("snooze_ignored", ringing, 1);
    snooze = 1'b0; cycle();
    check("snooze_ignored2", ringing, 1);
    press_stop();
    check("snooze_off_stop", ringing, 0);
`endif

    // 6: async reset mid-ring
    pulse_tick(0, 30, 7);
    pulse_tick(1, 30, 7);
    check("pre_reset_beep", beep, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_beep", beep, 0);
    check("async_ringing", ringing, 0);
    check("async_min", alarm_min, 0);
    check("async_hour", alarm_hour, 0);
    cycle();
    reset = 1'b0;
    cycle();
    pulse_tick(0, 30, 7);
    check("no_ring_after_reset", ringing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
